mpeg2_stream_unpacker: RTL and testbench

- Receive-side companion to the MPEG2 encoder's 256-bit output stream (o_en / o_last / o_data).
- Buffers encoder words in a small FIFO, serializes each word into bytes on a valid/ready byte interface, and flags MPEG2 start codes and the sequence end code.
- Sits between the encoder output and a byte-wide sink (UART/DMA bridge).
- The encoder has no backpressure, so FIFO overflow is detected and reported.

---
 rtl/mpeg2_stream_unpacker.sv | 121 ++++++++++++
 tb/tb_mpeg2_stream_unpacker.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpeg2_stream_unpacker.sv
// Receive-side unpacker for the MPEG2 encoder's 256-bit word stream: buffers words in a FIFO,
// serializes them to a valid/ready byte interface and flags start codes / sequence end.
module mpeg2_stream_unpacker #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic               i_last,
    input  logic [255:0]       i_data,
    output logic               o_byte_valid,
    input  logic               i_byte_ready,
    output logic [7:0]         o_byte,
    output logic               o_byte_last,
    output logic               o_start_code,
    output logic               o_seq_end,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_fifo_level
);

    localparam int unsigned        DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    logic [256:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [4:0]           idx_q, idx_d;
    logic [23:0]          hist_q, hist_d;
    logic [1:0]           fill_q, fill_d;
    logic                 ovf_q, ovf_d;

    logic [256:0]         head;
    logic [7:0]           cur_byte;
    logic                 valid, full, xfer, pop, push, last_byte, start_code;

    always_comb begin
        head       = mem_q[rd_ptr_q];
        valid      = (level_q != '0);
        full       = (level_q == DEPTH_L);
        cur_byte   = head[{idx_q, 3'b000} +: 8];
        last_byte  = valid & head[256] & (idx_q == 5'd31);
        xfer       = valid & i_byte_ready;
        pop        = xfer & (idx_q == 5'd31);
        push       = i_en & (~full | pop);
        // fill_q counts bytes seen since the history was cleared, so a cleared
        // (all-zero) history cannot masquerade as two leading zero bytes.
        start_code = valid & (hist_q == 24'h000001) & (fill_q == 2'd3);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        idx_d    = idx_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q | (i_en & ~push);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase

        if (xfer) begin
            idx_d = idx_q + 5'd1;
            if (last_byte) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = {hist_q[15:0], cur_byte};
                fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: every output is gated by a non-zero level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_last, i_data};
        end
    end

    always_comb begin
        o_byte_valid = valid;
        o_byte       = valid ? cur_byte : '0;
        o_byte_last  = last_byte;
        o_start_code = start_code;
        o_seq_end    = start_code & (cur_byte == 8'hB7);
        o_overflow   = ovf_q;
        o_fifo_level = level_q;
    end

endmodule

// File: tb/tb_mpeg2_stream_unpacker.sv
// Directed self-checking bench for mpeg2_stream_unpacker: serialization, start codes,
// backpressure, overflow, full push/pop edge and asynchronous reset mid-word.
module tb_mpeg2_stream_unpacker;

    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_en;
    logic          i_last;
    logic [255:0]  i_data;
    logic          o_byte_valid;
    logic          i_byte_ready;
    logic [7:0]    o_byte;
    logic          o_byte_last;
    logic          o_start_code;
    logic          o_seq_end;
    logic          o_overflow;
    logic [AW:0]   o_fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mpeg2_stream_unpacker #(.FIFO_AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_en         (i_en),
        .i_last       (i_last),
        .i_data       (i_data),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_byte       (o_byte),
        .o_byte_last  (o_byte_last),
        .o_start_code (o_start_code),
        .o_seq_end    (o_seq_end),
        .o_overflow   (o_overflow),
        .o_fifo_level (o_fifo_level)
    );

    function automatic logic [255:0] seq_word(input logic [7:0] base);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[8*k +: 8] = base + 8'(k);
        return w;
    endfunction

    task automatic hard_reset();
        i_en = 1'b0; i_last = 1'b0; i_data = '0; i_byte_ready = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        i_en = 1'b0; i_last = 1'b0; i_data = '0; i_byte_ready = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({o_byte_valid, o_byte_last, o_start_code, o_seq_end, o_overflow} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {o_byte_valid, o_byte_last, o_start_code, o_seq_end, o_overflow});
        end
        tests_run++;
        if (o_byte !== 8'h00) begin
            tests_failed++; $display("FAIL reset_byte: got %h expected 00", o_byte);
        end
        tests_run++;
        if (o_fifo_level !== 4'd0) begin
            tests_failed++; $display("FAIL reset_level: got %0d expected 0", o_fifo_level);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        i_data = seq_word(8'h00); i_last = 1'b1; i_en = 1'b1; i_byte_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_byte_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_latency: valid got %b expected 0 in push cycle", o_byte_valid);
        end
        @(posedge clk); #1;
        i_en = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            tests_run++;
            if ({o_byte_valid, o_byte, o_byte_last} !== {1'b1, 8'(k), (k == 31)}) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: got v=%b b=%h l=%b expected v=1 b=%h l=%b",
                         k, o_byte_valid, o_byte, o_byte_last, 8'(k), (k == 31));
            end
            if (k == 0) begin
                tests_run++;
                if (o_fifo_level !== 4'd1) begin
                    tests_failed++; $display("FAIL basic_level1: got %0d expected 1", o_fifo_level);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if ({o_byte_valid, o_fifo_level} !== {1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL basic_drain: got v=%b lvl=%0d expected v=0 lvl=0", o_byte_valid, o_fifo_level);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_codes();
        logic [255:0] w [3];
        logic [7:0]   exp_b [96];
        logic         exp_l, exp_sc, exp_se;
        int           got;
        for (int k = 0; k < 32; k++) begin
            w[0][8*k +: 8] = 8'h40 + 8'(k);
            w[1][8*k +: 8] = 8'h60 + 8'(k);
            w[2][8*k +: 8] = 8'h70 + 8'(k);
        end
        w[0][7:0] = 8'h00; w[0][15:8] = 8'h00; w[0][23:16] = 8'h01; w[0][31:24] = 8'hB3;
        w[0][231:224] = 8'h00; w[0][239:232] = 8'h00; w[0][247:240] = 8'h01; w[0][255:248] = 8'hB7;
        w[1][247:240] = 8'h00; w[1][255:248] = 8'h00;
        w[2][7:0] = 8'h00; w[2][15:8] = 8'h01; w[2][23:16] = 8'h22;
        for (int i = 0; i < 96; i++) exp_b[i] = w[i / 32][8*(i % 32) +: 8];
        got = 0;
        i_byte_ready = 1'b1;
        for (int c = 0; c < 300 && got < 96; c++) begin
            i_en   = (c < 3);
            i_data = (c < 3) ? w[c] : '0;
            i_last = (c == 1) || (c == 2);
            @(negedge clk);
            if (o_byte_valid && i_byte_ready) begin
                exp_sc = (got == 3) || (got == 31);
                exp_se = (got == 31);
                exp_l  = (got == 63) || (got == 95);
                tests_run++;
                if ({o_byte, o_byte_last, o_start_code, o_seq_end} !== {exp_b[got], exp_l, exp_sc, exp_se}) begin
                    tests_failed++;
                    $display("FAIL sc_byte%0d: got b=%h l=%b sc=%b se=%b expected b=%h l=%b sc=%b se=%b",
                             got, o_byte, o_byte_last, o_start_code, o_seq_end,
                             exp_b[got], exp_l, exp_sc, exp_se);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        i_en = 1'b0;
        tests_run++;
        if (got !== 96) begin
            tests_failed++; $display("FAIL sc_count: got %0d bytes expected 96", got);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic        pv, pr, pl, ps, pe;
        logic [7:0]  pb;
        int          got, maxlvl;
        pat = 16'b1011_0010_1101_0110;
        got = 0; maxlvl = 0; pv = 1'b0; pr = 1'b0; pb = '0; pl = 1'b0; ps = 1'b0; pe = 1'b0;
        for (int c = 0; c < 1000 && got < 96; c++) begin
            i_en         = (c < 3);
            i_data       = (c < 3) ? seq_word(8'(32 + 32 * c)) : '0;
            i_last       = (c == 2);
            i_byte_ready = pat[c % 16];
            @(negedge clk);
            if (int'(o_fifo_level) > maxlvl) maxlvl = int'(o_fifo_level);
            if (pv && !pr) begin
                tests_run++;
                if ({o_byte_valid, o_byte, o_byte_last, o_start_code, o_seq_end} !== {1'b1, pb, pl, ps, pe}) begin
                    tests_failed++;
                    $display("FAIL bp_stall_hold: got v=%b b=%h l=%b sc=%b se=%b expected v=1 b=%h l=%b sc=%b se=%b",
                             o_byte_valid, o_byte, o_byte_last, o_start_code, o_seq_end, pb, pl, ps, pe);
                end
            end
            if (o_byte_valid && i_byte_ready) begin
                tests_run++;
                if ({o_byte, o_byte_last} !== {8'(32 + got), (got == 95)}) begin
                    tests_failed++;
                    $display("FAIL bp_byte%0d: got b=%h l=%b expected b=%h l=%b",
                             got, o_byte, o_byte_last, 8'(32 + got), (got == 95));
                end
                got++;
            end
            pv = o_byte_valid; pr = i_byte_ready; pb = o_byte;
            pl = o_byte_last; ps = o_start_code; pe = o_seq_end;
            @(posedge clk); #1;
        end
        i_en = 1'b0; i_byte_ready = 1'b1;
        tests_run++;
        if (got !== 96) begin
            tests_failed++; $display("FAIL bp_count: got %0d bytes expected 96", got);
        end
        tests_run++;
        if (maxlvl !== 3) begin
            tests_failed++; $display("FAIL bp_peak_level: got %0d expected 3", maxlvl);
        end
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++; $display("FAIL bp_overflow: got %b expected 0", o_overflow);
        end
    endtask

    task automatic test_overflow();
        int got;
        i_byte_ready = 1'b0; i_last = 1'b0;
        for (int w = 0; w < 9; w++) begin
            i_en = 1'b1; i_data = seq_word(8'(w * 16));
            @(posedge clk); #1;
            if (w == 7) begin
                tests_run++;
                if ({o_fifo_level, o_overflow} !== {4'd8, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL ovf_after8: got lvl=%0d ovf=%b expected lvl=8 ovf=0", o_fifo_level, o_overflow);
                end
            end
        end
        i_en = 1'b0;
        tests_run++;
        if ({o_fifo_level, o_overflow} !== {4'd8, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_after9: got lvl=%0d ovf=%b expected lvl=8 ovf=1", o_fifo_level, o_overflow);
        end
        i_byte_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 400 && got < 256; c++) begin
            @(negedge clk);
            if (o_byte_valid && i_byte_ready) begin
                tests_run++;
                if (o_byte !== 8'((got / 32) * 16 + (got % 32))) begin
                    tests_failed++;
                    $display("FAIL ovf_byte%0d: got %h expected %h", got, o_byte,
                             8'((got / 32) * 16 + (got % 32)));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if ({got == 256, o_byte_valid, o_overflow} !== 3'b101) begin
            tests_failed++;
            $display("FAIL ovf_drain: got count=%0d v=%b ovf=%b expected count=256 v=0 ovf=1",
                     got, o_byte_valid, o_overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_push_pop();
        int got;
        logic [7:0] eb;
        hard_reset();
        i_last = 1'b0;
        for (int w = 0; w < 8; w++) begin
            i_en = 1'b1; i_data = seq_word(8'(w * 16));
            @(posedge clk); #1;
        end
        i_en = 1'b0;
        i_byte_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 600 && got < 288; c++) begin
            i_en   = (c == 31);
            i_data = (c == 31) ? seq_word(8'hC0) : '0;
            i_last = (c == 31);
            @(negedge clk);
            if (c == 31 || c == 32) begin
                tests_run++;
                if ({o_fifo_level, o_overflow} !== {4'd8, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL fpp_level_c%0d: got lvl=%0d ovf=%b expected lvl=8 ovf=0",
                             c, o_fifo_level, o_overflow);
                end
            end
            if (o_byte_valid && i_byte_ready) begin
                eb = (got < 256) ? 8'((got / 32) * 16 + (got % 32)) : 8'hC0 + 8'(got - 256);
                tests_run++;
                if ({o_byte, o_byte_last} !== {eb, (got == 287)}) begin
                    tests_failed++;
                    $display("FAIL fpp_byte%0d: got b=%h l=%b expected b=%h l=%b",
                             got, o_byte, o_byte_last, eb, (got == 287));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        i_en = 1'b0; i_last = 1'b0;
        tests_run++;
        if (got !== 288) begin
            tests_failed++; $display("FAIL fpp_count: got %0d bytes expected 288", got);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [255:0] wr, wn;
        wr = seq_word(8'h50);
        wr[71:64] = 8'h00; wr[79:72] = 8'h00;
        wn = seq_word(8'h30);
        wn[7:0] = 8'h01; wn[15:8] = 8'hB3;
        i_byte_ready = 1'b1; i_last = 1'b0; i_en = 1'b1; i_data = wr;
        @(posedge clk); #1;
        i_en = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            tests_run++;
            if (o_byte !== wr[8*k +: 8]) begin
                tests_failed++; $display("FAIL rst_pre_byte%0d: got %h expected %h", k, o_byte, wr[8*k +: 8]);
            end
            if (k < 10) begin
                @(posedge clk); #1;
            end
        end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({o_byte_valid, o_byte, o_byte_last, o_start_code, o_seq_end, o_overflow, o_fifo_level} !== '0) begin
            tests_failed++;
            $display("FAIL rst_async_outputs: got v=%b b=%h l=%b sc=%b se=%b ovf=%b lvl=%0d expected all 0",
                     o_byte_valid, o_byte, o_byte_last, o_start_code, o_seq_end, o_overflow, o_fifo_level);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_byte_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_release_valid: got %b expected 0", o_byte_valid);
        end
        @(posedge clk); #1;
        i_en = 1'b1; i_last = 1'b1; i_data = wn;
        @(posedge clk); #1;
        i_en = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            tests_run++;
            if ({o_byte_valid, o_byte, o_byte_last, o_start_code} !== {1'b1, wn[8*k +: 8], (k == 31), 1'b0}) begin
                tests_failed++;
                $display("FAIL rst_post_byte%0d: got v=%b b=%h l=%b sc=%b expected v=1 b=%h l=%b sc=0",
                         k, o_byte_valid, o_byte, o_byte_last, o_start_code, wn[8*k +: 8], (k == 31));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if ({o_byte_valid, o_fifo_level} !== {1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL rst_post_drain: got v=%b lvl=%0d expected v=0 lvl=0", o_byte_valid, o_fifo_level);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_codes();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1);
    end

endmodule
